sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter_pkg.sv | 19 +
 rtl/sram_arb_grant.sv | 26 ++
 rtl/sram_port_arbiter.sv | 126 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the IF/MEM single-port SRAM arbiter: FSM state encoding, counter and byte-select types.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    localparam int CNT_W = 4;
    localparam int SEL_W = 4;

    typedef logic [CNT_W-1:0] arb_cnt_t;
    typedef logic [SEL_W-1:0] sel_t;

    // Fetches always read a full word.
    localparam sel_t SEL_ALL = '1;

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational grant select between fetch and load/store requesters.
// SRAM_ARB_RR_EN: alternate on simultaneous requests using last_mem; otherwise strict MEM-over-IF priority.
module sram_arb_grant
    import sram_port_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic mem_req,
    input  logic last_mem,
    output logic gnt_if,
    output logic gnt_mem
);

`ifdef SRAM_ARB_RR_EN
    // On a tie the requester that did not win last time goes first.
    assign gnt_if  = if_req  & (~mem_req | last_mem);
    assign gnt_mem = mem_req & ~(if_req & last_mem);
`else
    logic unused_last_mem;
    assign unused_last_mem = last_mem;

    // MEM holds the older instruction, so it wins every tie.
    assign gnt_mem = mem_req;
    assign gnt_if  = if_req & ~mem_req;
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one fixed-latency single-port SRAM between IF and MEM: IDLE -> ACCESS (WAIT_CYCLES) -> RESP -> IDLE.
// Optional SRAM_ARB_RR_EN adds a round-robin tie-break flag.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [3:0]        sram_sel_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o
);

    localparam arb_cnt_t CNT_LOAD = arb_cnt_t'(WAIT_CYCLES - 1);

    arb_state_e state;
    arb_cnt_t   cnt;
    logic       owner_mem;
    logic       gnt_if;
    logic       gnt_mem;
    logic       last_mem;

    sram_arb_grant u_grant (
        .if_req   (if_req_i),
        .mem_req  (mem_req_i),
        .last_mem (last_mem),
        .gnt_if   (gnt_if),
        .gnt_mem  (gnt_mem)
    );

    // The SRAM-facing outputs double as the latched request, so they are stable for the whole access.
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARB_IDLE;
            cnt          <= '0;
            owner_mem    <= 1'b0;
            sram_ce_o    <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_sel_o   <= '0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
            if_ack_o     <= 1'b0;
            mem_ack_o    <= 1'b0;
            if_rdata_o   <= '0;
            mem_rdata_o  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (gnt_if || gnt_mem) begin
                        state        <= ARB_ACCESS;
                        cnt          <= CNT_LOAD;
                        owner_mem    <= gnt_mem;
                        sram_ce_o    <= 1'b1;
                        sram_we_o    <= gnt_mem & mem_we_i;
                        sram_sel_o   <= gnt_mem ? mem_sel_i : SEL_ALL;
                        sram_addr_o  <= gnt_mem ? mem_addr_i : if_addr_i;
                        sram_wdata_o <= gnt_mem ? mem_wdata_i : '0;
                    end
                end
                ARB_ACCESS: begin
                    if (cnt == '0) begin
                        state        <= ARB_RESP;
                        sram_ce_o    <= 1'b0;
                        sram_we_o    <= 1'b0;
                        sram_sel_o   <= '0;
                        sram_addr_o  <= '0;
                        sram_wdata_o <= '0;
                        if_ack_o     <= ~owner_mem;
                        mem_ack_o    <= owner_mem;
                        if (!sram_we_o) begin
                            if (owner_mem) mem_rdata_o <= sram_rdata_i;
                            else           if_rdata_o  <= sram_rdata_i;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ARB_RESP: begin
                    // Always pass through IDLE so a requester that reacts to ack is not sampled twice.
                    state     <= ARB_IDLE;
                    if_ack_o  <= 1'b0;
                    mem_ack_o <= 1'b0;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef SRAM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_mem <= 1'b0;
        end else if (state == ARB_IDLE) begin
            if (gnt_mem)     last_mem <= 1'b1;
            else if (gnt_if) last_mem <= 1'b0;
        end
    end
`else
    assign last_mem = 1'b0;
`endif

    assign stallreq_if_o  = if_req_i  & ~if_ack_o;
    assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one instance at WAIT_CYCLES=2, one at WAIT_CYCLES=1 for back-to-back reads.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;

    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
    logic        if_ack, mem_ack, sram_ce, sram_we, stallreq_if, stallreq_mem;
    logic [3:0]  sram_sel;

    logic        if_req2, mem_req2, mem_we2;
    logic [31:0] if_addr2, mem_addr2, mem_wdata2;
    logic [3:0]  mem_sel2;
    logic [31:0] if_rdata2, mem_rdata2, sram_addr2, sram_wdata2, sram_rdata2;
    logic        if_ack2, mem_ack2, sram_ce2, sram_we2, stallreq_if2, stallreq_mem2;
    logic [3:0]  sram_sel2;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        case (a)
            32'h100: return 32'h3C01_0001;
            32'h200: return 32'h1234_5678;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign sram_rdata  = (sram_ce  && !sram_we)  ? model_rd(sram_addr)  : 32'h0;
    assign sram_rdata2 = (sram_ce2 && !sram_we2) ? model_rd(sram_addr2) : 32'h0;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack),
        .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_sel_o(sram_sel), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
        .stallreq_if_o(stallreq_if), .stallreq_mem_o(stallreq_mem)
    );

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .if_req_i(if_req2), .if_addr_i(if_addr2), .if_rdata_o(if_rdata2), .if_ack_o(if_ack2),
        .mem_req_i(mem_req2), .mem_we_i(mem_we2), .mem_sel_i(mem_sel2), .mem_addr_i(mem_addr2),
        .mem_wdata_i(mem_wdata2), .mem_rdata_o(mem_rdata2), .mem_ack_o(mem_ack2),
        .sram_ce_o(sram_ce2), .sram_we_o(sram_we2), .sram_sel_o(sram_sel2), .sram_addr_o(sram_addr2),
        .sram_wdata_o(sram_wdata2), .sram_rdata_i(sram_rdata2),
        .stallreq_if_o(stallreq_if2), .stallreq_mem_o(stallreq_mem2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        int mem_k, if_k, ack_k, we_cycles, n, ns, hits;
        int  acks[4];
        logic [31:0] served[8];
        logic        order[4];

        rst = 1'b0;
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_sel = 0; mem_addr = 0; mem_wdata = 0;
        if_req2 = 0; if_addr2 = 0; mem_req2 = 0; mem_we2 = 0; mem_sel2 = 0; mem_addr2 = 0; mem_wdata2 = 0;

        // Reset state
        #12;
        check("rst ce", {31'd0, sram_ce}, 0);
        check("rst acks", {30'd0, if_ack, mem_ack}, 0);
        check("rst if_rdata", if_rdata, 0);
        check("rst mem_rdata", mem_rdata, 0);
        check("rst sram_addr", sram_addr, 0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // 1: single IF read
        if_req = 1; if_addr = 32'h100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            case (k)
                0: begin
                    check("t1 ce before grant", {31'd0, sram_ce}, 0);
                    check("t1 stall before grant", {31'd0, stallreq_if}, 1);
                end
                1, 2: begin
                    check("t1 ce access", {31'd0, sram_ce}, 1);
                    check("t1 addr access", sram_addr, 32'h100);
                    check("t1 sel access", {28'd0, sram_sel}, 32'hF);
                    check("t1 we access", {31'd0, sram_we}, 0);
                    check("t1 ack early", {31'd0, if_ack}, 0);
                    check("t1 stall access", {31'd0, stallreq_if}, 1);
                end
                3: begin
                    check("t1 ack", {31'd0, if_ack}, 1);
                    check("t1 rdata", if_rdata, 32'h3C01_0001);
                    check("t1 stall at ack", {31'd0, stallreq_if}, 0);
                    check("t1 ce resp", {31'd0, sram_ce}, 0);
                    check("t1 addr resp", sram_addr, 0);
                end
                default: check("t1 ack one pulse", {31'd0, if_ack}, 0);
            endcase
            @(posedge clk); #1;
            if (k == 3) if_req = 0;
        end

        // 2: IF and MEM together, MEM first
        mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h200;
        if_req = 1; if_addr = 32'h104;
        mem_k = -1; if_k = -1; hits = 0;
        for (int k = 0; k < 16 && if_k < 0; k++) begin
            @(negedge clk);
            if (mem_ack && mem_k < 0) mem_k = k;
            if (if_ack) if_k = k;
            if (if_k < 0 && !stallreq_if) hits++;
            @(posedge clk); #1;
            if (k == mem_k) mem_req = 0;
            if (k == if_k) if_req = 0;
        end
        check("t2 mem ack cycle", mem_k, 3);
        check("t2 if ack cycle", if_k, 7);
        check("t2 stall_if drops", hits, 0);
        check("t2 mem rdata", mem_rdata, 32'h1234_5678);
        check("t2 if rdata", if_rdata, 32'hA5A5_0104);

        // 3: MEM write leaves mem_rdata alone
        mem_req = 1; mem_we = 1; mem_sel = 4'b0011; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF;
        ack_k = -1; we_cycles = 0;
        for (int k = 0; k < 10 && ack_k < 0; k++) begin
            @(negedge clk);
            if (sram_we) begin
                we_cycles++;
                check("t3 sel", {28'd0, sram_sel}, 32'h3);
                check("t3 addr", sram_addr, 32'h40);
                check("t3 wdata", sram_wdata, 32'hDEAD_BEEF);
            end
            if (mem_ack) ack_k = k;
            @(posedge clk); #1;
            if (k == ack_k) begin mem_req = 0; mem_we = 0; end
        end
        check("t3 we cycles", we_cycles, 2);
        check("t3 ack cycle", ack_k, 3);
        check("t3 mem rdata kept", mem_rdata, 32'h1234_5678);

        // 4: reset in the second ACCESS cycle
        if_req = 1; if_addr = 32'h100;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t4 ce before rst", {31'd0, sram_ce}, 1);
        rst = 1'b0;
        #1;
        check("t4 ce", {31'd0, sram_ce}, 0);
        check("t4 addr", sram_addr, 0);
        check("t4 sel/we", {27'd0, sram_sel, sram_we}, 0);
        check("t4 acks", {30'd0, if_ack, mem_ack}, 0);
        check("t4 if rdata", if_rdata, 0);
        check("t4 mem rdata", mem_rdata, 0);
        if_req = 0;
        @(posedge clk); #1; rst = 1'b1;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (if_ack || mem_ack || sram_ce) hits++;
        end
        check("t4 no activity after release", hits, 0);
        check("t4 if rdata after release", if_rdata, 0);
        @(posedge clk); #1;

        // 5: both held for four grants
        mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h300;
        if_req = 1; if_addr = 32'h400;
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (mem_ack && n < 4) begin order[n] = 1'b1; n++; end
            if (if_ack && n < 4)  begin order[n] = 1'b0; n++; end
            if (n < 4) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        mem_req = 0; if_req = 0;
        check("t5 grants", n, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
            check($sformatf("t5 grant %0d is mem", i), {31'd0, order[i]}, (i % 2 == 0) ? 1 : 0);
`else
            check($sformatf("t5 grant %0d is mem", i), {31'd0, order[i]}, 1);
`endif
        end
        repeat (6) @(posedge clk);
        #1;

        // 6: WAIT_CYCLES=1 back-to-back MEM reads
        mem_req2 = 1; mem_we2 = 0; mem_sel2 = 4'hF; mem_addr2 = 32'h10;
        n = 0; ns = 0;
        for (int k = 0; k < 30 && n < 4; k++) begin
            @(negedge clk);
            if (sram_ce2 && ns < 8) begin served[ns] = sram_addr2; ns++; end
            ack_k = -1;
            if (mem_ack2) begin
                acks[n] = k;
                check($sformatf("t6 rdata %0d", n), mem_rdata2, model_rd(32'h10 + 32'(n * 4)));
                n++;
                ack_k = k;
            end
            @(posedge clk); #1;
            if (ack_k >= 0) begin
                if (n == 4) mem_req2 = 0;
                else        mem_addr2 = mem_addr2 + 32'd4;
            end
        end
        check("t6 acks", n, 4);
        check("t6 first ack", acks[0], 2);
        for (int i = 1; i < 4; i++)
            check($sformatf("t6 spacing %0d", i), acks[i] - acks[i-1], 3);
        check("t6 ce cycles", ns, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t6 served addr %0d", i), served[i], 32'h10 + 32'(i * 4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
